float_adder_pipe_norm_out: RTL and testbench

- Final normalize/round stage of the pipelined float adder.
- Consumes the calc-to-normalize pipeline register fields (rm, inf/nan, sign, exp, 28-bit frac) and produces the IEEE-754 single-precision result.
- Returns the stall enable to the upstream pipeline registers.
- Presents results through a 2-entry output buffer with a valid/ready handshake toward the writeback/FPR interface.

---
 rtl/fp_add_pkg.sv | 26 ++
 rtl/float_adder_pipe_norm_out_lzc.sv | 15 +
 rtl/float_adder_pipe_norm_out.sv | 170 +++++++++++++++++
 tb/tb_float_adder_pipe_norm_out.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared encodings, widths and constants for the pipelined float adder.
// Optional flag output is enabled by defining FP_ADD_FLAGS_EN.
package fp_add_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int GFRAC_W = 28;

    localparam logic [EXP_W-1:0]  EXP_MAX   = 8'hff;
    localparam logic [EXP_W-1:0]  EXP_MAXF  = 8'hfe;
    localparam logic [FRAC_W-1:0] FRAC_MAXF = 23'h7fffff;

    typedef enum logic [1:0] {
        RM_NEAR = 2'b00,
        RM_NEG  = 2'b01,
        RM_POS  = 2'b10,
        RM_ZERO = 2'b11
    } rm_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/float_adder_pipe_norm_out_lzc.sv
// 27-bit leading-zero counter for the normalize stage; all-zero input yields 27.
module float_norm_lzc (
    input  logic [26:0] din_i,
    output logic [4:0]  cnt_o
);

    always_comb begin
        cnt_o = 5'd27;
        // Ascending scan: the highest set bit is the last to write.
        for (int i = 0; i < 27; i++) begin
            if (din_i[i]) cnt_o = 5'(26 - i);
        end
    end

endmodule

// File: rtl/float_adder_pipe_norm_out.sv
// Normalize/round stage with a DEPTH-entry result buffer and valid/ready output.
// Define FP_ADD_FLAGS_EN to add the per-result {overflow, underflow, inexact} flags.
module float_adder_pipe_norm_out
    import fp_add_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [1:0]          n_rm,
    input  logic                n_inf_nan,
    input  logic [FRAC_W-1:0]   n_inf_nan_frac,
    input  logic                n_sign,
    input  logic [EXP_W-1:0]    n_exp,
    input  logic [GFRAC_W-1:0]  n_frac,
    output logic                en,
    output logic                res_valid,
    input  logic                res_ready,
`ifdef FP_ADD_FLAGS_EN
    output logic [2:0]          res_flags,
`endif
    output logic [31:0]         res
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [4:0]  lz;
    logic [7:0]  shift_lim;
    logic [4:0]  shamt;
    logic [26:0] m_pre;
    logic [9:0]  e_pre;
    logic [9:0]  e_norm;
    logic        inc;
    logic [24:0] sum;
    logic [9:0]  e_rnd;
    logic [22:0] frac_rnd;
    logic        ovf;
    rm_e         rm;
    fp32_t       wr_res;

    float_norm_lzc u_lzc (
        .din_i (n_frac[26:0]),
        .cnt_o (lz)
    );

    assign rm        = rm_e'(n_rm);
    assign shift_lim = n_exp - 8'd1;

    // m_pre keeps {hidden, fraction[22:0], guard, round, sticky}.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        shamt = 5'd0;
        m_pre = n_frac[26:0];
        e_pre = {2'b00, n_exp};
        if (n_frac[27]) begin
            m_pre = {n_frac[27:2], |n_frac[1:0]};
            e_pre = {2'b00, n_exp} + 10'd1;
        end else if (!n_frac[26] && n_exp > 8'd1) begin
            shamt = ({3'b000, lz} < shift_lim) ? lz : shift_lim[4:0];
            m_pre = n_frac[26:0] << shamt;
            e_pre = {2'b00, n_exp} - {5'b00000, shamt};
        end
        // A mantissa still lacking its hidden bit is denormal.
        e_norm = m_pre[26] ? e_pre : 10'd0;
    end

    always_comb begin
        unique case (rm)
            RM_NEAR: inc = m_pre[2] && (m_pre[1] || m_pre[0] || m_pre[3]);
            RM_NEG:  inc = n_sign && (|m_pre[2:0]);
            RM_POS:  inc = !n_sign && (|m_pre[2:0]);
            RM_ZERO: inc = 1'b0;
            default: inc = 1'b0;
        endcase
        sum      = {1'b0, m_pre[26:3]} + {24'd0, inc};
        e_rnd    = e_norm;
        frac_rnd = sum[22:0];
        if (sum[24]) begin
            e_rnd    = e_norm + 10'd1;
            frac_rnd = sum[23:1];
        end else if (e_norm == 10'd0 && sum[23]) begin
            e_rnd = 10'd1;
        end
        ovf = (e_rnd >= {2'b00, EXP_MAX});
    end

    always_comb begin
        wr_res = '{sign: n_sign, exp: e_rnd[7:0], frac: frac_rnd};
        if (n_inf_nan) begin
            wr_res = '{sign: n_sign, exp: EXP_MAX, frac: n_inf_nan_frac};
        end else if (n_frac == '0) begin
            wr_res = '{sign: n_sign, exp: '0, frac: '0};
        end else if (ovf) begin
            if (rm == RM_NEAR || (rm == RM_NEG && n_sign) || (rm == RM_POS && !n_sign))
                wr_res = '{sign: n_sign, exp: EXP_MAX, frac: '0};
            else
                wr_res = '{sign: n_sign, exp: EXP_MAXF, frac: FRAC_MAXF};
        end
    end

`ifdef FP_ADD_FLAGS_EN
    logic       inexact;
    logic [2:0] wr_flags;

    always_comb begin
        inexact  = |m_pre[2:0];
        wr_flags = {1'b0, (e_rnd == 10'd0) && inexact, inexact};
        if (n_inf_nan || n_frac == '0) wr_flags = 3'b000;
        else if (ovf)                  wr_flags = 3'b101;
    end
`endif

    fp32_t             mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push;
    logic              pop;

    assign en        = (count_q < CNT_W'(DEPTH));
    assign res_valid = (count_q != '0);
    assign res       = mem_q[rd_ptr_q];
    assign push      = in_valid && en;
    assign pop       = res_valid && res_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            // NOTE: buffer entries are reset so res reads 0 straight out of reset.
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= wr_res;
        end
    end

`ifdef FP_ADD_FLAGS_EN
    logic [2:0] flg_q [DEPTH];

    assign res_flags = flg_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) flg_q[i] <= 3'b000;
        end else if (push) begin
            flg_q[wr_ptr_q] <= wr_flags;
        end
    end
`endif

endmodule

// File: tb/tb_float_adder_pipe_norm_out.sv
// Scoreboard bench for float_adder_pipe_norm_out: directed cases, backpressure,
// async reset and randomized ops checked against an exact-arithmetic rounding model.
module tb_float_adder_pipe_norm_out;

    typedef struct {
        bit [1:0]  rm;
        bit        inf_nan;
        bit [22:0] nf;
        bit        sign;
        bit [7:0]  exp;
        bit [27:0] frac;
    } op_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        bit          flag_chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  n_rm;
    logic        n_inf_nan;
    logic [22:0] n_inf_nan_frac;
    logic        n_sign;
    logic [7:0]  n_exp;
    logic [27:0] n_frac;
    logic        en;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res;
`ifdef FP_ADD_FLAGS_EN
    logic [2:0]  res_flags;
`endif

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 2;   // 0 random, 1 hold low, 2 hold high
    exp_t sb [$];

    always #5 clk = ~clk;

    float_adder_pipe_norm_out dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .n_rm           (n_rm),
        .n_inf_nan      (n_inf_nan),
        .n_inf_nan_frac (n_inf_nan_frac),
        .n_sign         (n_sign),
        .n_exp          (n_exp),
        .n_frac         (n_frac),
        .en             (en),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
`ifdef FP_ADD_FLAGS_EN
        .res_flags      (res_flags),
`endif
        .res            (res)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Value = M * 2^(E-153) with E = max(exp,1); re-quantize to a 24-bit significand.
    function automatic logic [34:0] model(input op_t o);
        longint m, q, rem, half;
        int     ee, eo, d, p;
        bit     inc, inexact;
        logic [7:0] ef;
        if (o.inf_nan)    return {3'b000, o.sign, 8'hff, o.nf};
        if (o.frac == '0) return {3'b000, o.sign, 31'h0};
        m  = longint'(o.frac);
        ee = (o.exp == 8'd0) ? 1 : int'(o.exp);
        p  = 0;
        for (int i = 0; i < 28; i++) if (o.frac[i]) p = i;
        eo = p + ee - 26;
        if (eo < 1) eo = 1;
        d = eo - ee + 3;
        if (d > 0) begin
            q    = m >> d;
            rem  = m & ((longint'(1) << d) - 1);
            half = longint'(1) << (d - 1);
        end else begin
            q    = m << (-d);
            rem  = 0;
            half = 1;
        end
        case (o.rm)
            2'b00:   inc = (rem > half) || (rem == half && q[0]);
            2'b01:   inc = o.sign && (rem != 0);
            2'b10:   inc = !o.sign && (rem != 0);
            default: inc = 1'b0;
        endcase
        q = q + longint'(inc);
        if (q == (longint'(1) << 24)) begin
            q  = q >> 1;
            eo = eo + 1;
        end
        inexact = (rem != 0);
        if (eo >= 255) begin
            if (o.rm == 2'b00 || (o.rm == 2'b01 && o.sign) || (o.rm == 2'b10 && !o.sign))
                return {3'b101, o.sign, 8'hff, 23'h0};
            return {3'b101, o.sign, 8'hfe, 23'h7fffff};
        end
        ef = (eo == 1 && q < (longint'(1) << 23)) ? 8'd0 : 8'(eo);
        return {1'b0, (ef == 8'd0) && inexact, inexact, o.sign, ef, q[22:0]};
    endfunction

    // Holds the op until en allows it; the expected result is queued at the accepting edge.
    task automatic issue(input op_t o, input exp_t e);
        int w = 0;
        @(negedge clk);
        n_rm = o.rm; n_inf_nan = o.inf_nan; n_inf_nan_frac = o.nf;
        n_sign = o.sign; n_exp = o.exp; n_frac = o.frac;
        in_valid = 1'b1;
        while (!en && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!en) begin
            fail("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(e);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue_model(input op_t o);
        logic [34:0] r;
        exp_t e;
        r = model(o);
        e.res = r[31:0]; e.flags = r[34:32]; e.flag_chk = 1'b1;
        issue(o, e);
    endtask

    task automatic issue_const(input op_t o, input logic [31:0] want);
        exp_t e;
        e.res = want; e.flags = 3'b000; e.flag_chk = 1'b0;
        issue(o, e);
    endtask

    task automatic drain();
        int w = 0;
        while ((sb.size() != 0 || res_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0 || res_valid) fail("drain_timeout");
    endtask

    function automatic op_t mk(input bit [1:0] rm, input bit sign, input bit [7:0] exp, input bit [27:0] frac);
        op_t o;
        o.rm = rm; o.inf_nan = 1'b0; o.nf = '0; o.sign = sign; o.exp = exp; o.frac = frac;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        logic [31:0] f;
        o.rm      = 2'($urandom_range(0, 3));
        o.sign    = 1'($urandom_range(0, 1));
        o.inf_nan = ($urandom_range(0, 15) == 0);
        o.nf      = 23'($urandom);
        case ($urandom_range(0, 3))
            0:       o.exp = 8'($urandom_range(0, 4));
            1:       o.exp = 8'($urandom_range(250, 255));
            default: o.exp = 8'($urandom_range(5, 249));
        endcase
        f      = $urandom;
        o.frac = f[27:0] >> $urandom_range(0, 27);
        if ($urandom_range(0, 31) == 0) o.frac = '0;
        if (o.exp == 8'd0) o.frac[27:26] = 2'b00;
        return o;
    endfunction

    // Monitor: compares the buffer head whenever valid, pops on handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       res_ready = ($urandom_range(0, 3) != 0);
                1:       res_ready = 1'b0;
                default: res_ready = 1'b1;
            endcase
            if (res_valid && rst_n) begin
                if (sb.size() == 0) begin
                    fail("unexpected_result");
                end else begin
                    e = sb[0];
                    check("res", res, e.res);
`ifdef FP_ADD_FLAGS_EN
                    if (e.flag_chk) check("res_flags", {29'd0, res_flags}, {29'd0, e.flags});
`endif
                    if (res_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        op_t o;
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        n_rm = '0; n_inf_nan = 1'b0; n_inf_nan_frac = '0; n_sign = 1'b0; n_exp = '0; n_frac = '0;
        #3;
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_en", {31'd0, en}, 32'd1);
        check("reset_res", res, 32'h0);
        @(negedge clk); #2 rst_n = 1'b1;

        ready_mode = 2;
        issue_const(mk(2'b00, 1'b0, 8'h7f, 28'h4000000), 32'h3F800000);
        check("latency_valid", {31'd0, res_valid}, 32'd1);
        issue_const(mk(2'b00, 1'b0, 8'h7f, 28'h8000000), 32'h40000000);
        issue_const(mk(2'b00, 1'b0, 8'h7f, 28'h2000000), 32'h3F000000);
        issue_const(mk(2'b00, 1'b0, 8'h7f, 28'h4000004), 32'h3F800000);
        issue_const(mk(2'b10, 1'b0, 8'h7f, 28'h4000004), 32'h3F800001);
        issue_const(mk(2'b01, 1'b1, 8'h7f, 28'h4000004), 32'hBF800001);
        o = mk(2'b00, 1'b0, 8'hfe, 28'h8000000);
        e.res = 32'h7F800000; e.flags = 3'b101; e.flag_chk = 1'b1;
        issue(o, e);
        issue_const(mk(2'b11, 1'b0, 8'hfe, 28'h8000000), 32'h7F7FFFFF);
        o = mk(2'b00, 1'b0, 8'($urandom), 28'($urandom));
        o.inf_nan = 1'b1; o.nf = 23'h400000;
        issue_const(o, 32'h7FC00000);
        drain();

        // Backpressure: two ops fill the buffer, the third waits upstream.
        @(posedge clk); #1 ready_mode = 1;
        issue_model(rand_op());
        issue_model(rand_op());
        check("en_full", {31'd0, en}, 32'd0);
        o = rand_op();
        @(negedge clk);
        n_rm = o.rm; n_inf_nan = o.inf_nan; n_inf_nan_frac = o.nf;
        n_sign = o.sign; n_exp = o.exp; n_frac = o.frac; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("en_held", {31'd0, en}, 32'd0);
        end
        #1 ready_mode = 2;
        issue_model(o);
        check("en_recover", {31'd0, en}, 32'd1);
        drain();

        for (int i = 0; i < 300; i++) begin
            if (i == 0) begin @(posedge clk); #1 ready_mode = 0; end
            issue_model(rand_op());
        end
        @(posedge clk); #1 ready_mode = 2;
        drain();

        // Async reset with two buffered results.
        @(posedge clk); #1 ready_mode = 1;
        issue_model(rand_op());
        issue_model(rand_op());
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_en", {31'd0, en}, 32'd1);
        check("rst_res", res, 32'h0);
        sb.delete();
        @(negedge clk); #2 rst_n = 1'b1;
        ready_mode = 2;

        for (int i = 0; i < 20; i++) issue_model(rand_op());
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
